// File: rtl/pvt_uart_host.sv
// Host-side command link master: serializes write/read command frames on tx_out and
// deserializes the single-byte read response from rx_in; one request in flight at a time.
module pvt_uart_host #(
  parameter int BIT_CYCLES     = 1,
  parameter int GAP_BITS       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [4:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       busy,
  output logic       tx_out,
  input  logic       rx_in
);

  localparam int GAP_CYCLES = GAP_BITS * BIT_CYCLES;
  localparam int M1         = (GAP_CYCLES > BIT_CYCLES) ? GAP_CYCLES : BIT_CYCLES;
  localparam int MAXC       = (TIMEOUT_CYCLES > M1) ? TIMEOUT_CYCLES : M1;
  localparam int CW         = $clog2(MAXC + 1) + 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, TX_GAP, RX_WAIT, RX_DATA, RX_STOP, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic          data_phase, phase_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          rw_q;
  logic [4:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rdata_nxt;
  logic [1:0]    err_nxt;
  logic [7:0]    cur_byte;
  logic          tx_nxt;
  logic          accept;
  logic          bit_end;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && (state == IDLE);
  assign bit_end   = (cnt == BIT_LAST);
  assign cur_byte  = data_phase ? wdata_q : {(rw_q ? 3'd2 : 3'd0), addr_q};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    bit_nxt   = bit_idx;
    phase_nxt = data_phase;
    shreg_nxt = shreg;
    rdata_nxt = rsp_rdata;
    err_nxt   = rsp_err;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) begin
          state_nxt = TX_START;
          phase_nxt = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_nxt = TX_DATA;
          cnt_nxt   = '0;
          bit_nxt   = 3'd7;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd0) state_nxt = TX_STOP;
          else                 bit_nxt   = bit_idx - 3'd1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (data_phase) begin
            state_nxt = DONE;
            rdata_nxt = 8'h00;
            err_nxt   = 2'b00;
          end else if (rw_q) begin
            state_nxt = RX_WAIT;
          end else begin
            phase_nxt = 1'b1;
            state_nxt = (GAP_BITS > 0) ? TX_GAP : TX_START;
          end
        end
      end
      TX_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = TX_START;
          cnt_nxt   = '0;
        end
      end
      RX_WAIT: begin
        // A start bit on the final timeout cycle still wins over the timeout.
        if (!rx_in) begin
          state_nxt = RX_DATA;
          cnt_nxt   = '0;
          bit_nxt   = 3'd7;
        end else if (cnt == TO_LIM) begin
          state_nxt = DONE;
          rdata_nxt = 8'h00;
          err_nxt   = 2'b10;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          shreg_nxt = {shreg[6:0], rx_in};
          if (bit_idx == 3'd0) state_nxt = RX_STOP;
          else                 bit_nxt   = bit_idx - 3'd1;
        end
      end
      RX_STOP: begin
        if (bit_end) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          rdata_nxt = rx_in ? shreg : 8'h00;
          err_nxt   = rx_in ? 2'b00 : 2'b01;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // tx_out is registered, so it is driven from the state being entered.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      TX_START: tx_nxt = 1'b0;
      TX_DATA:  tx_nxt = cur_byte[bit_nxt];
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      data_phase <= 1'b0;
      shreg      <= 8'h00;
      rw_q       <= 1'b0;
      addr_q     <= 5'd0;
      wdata_q    <= 8'h00;
      tx_out     <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
      rsp_err    <= 2'b00;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_nxt;
      data_phase <= phase_nxt;
      shreg      <= shreg_nxt;
      tx_out     <= tx_nxt;
      rsp_valid  <= (state_nxt == DONE);
      rsp_rdata  <= rdata_nxt;
      rsp_err    <= err_nxt;
      if (accept) begin
        rw_q    <= req_rw;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_pvt_uart_host.sv
// Directed bench for pvt_uart_host: instance a (1 cycle/bit, no gap, timeout 16)
// and instance b (4 cycles/bit, 2 gap bits).
module tb_pvt_uart_host;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  logic       rst_a, req_valid_a, req_ready_a, req_rw_a, rsp_valid_a, busy_a, tx_a, rx_a;
  logic [4:0] req_addr_a;
  logic [7:0] req_wdata_a, rsp_rdata_a;
  logic [1:0] rsp_err_a;

  logic       rst_b, req_valid_b, req_ready_b, req_rw_b, rsp_valid_b, busy_b, tx_b, rx_b;
  logic [4:0] req_addr_b;
  logic [7:0] req_wdata_b, rsp_rdata_b;
  logic [1:0] rsp_err_b;

  pvt_uart_host #(.BIT_CYCLES(1), .GAP_BITS(0), .TIMEOUT_CYCLES(16)) u_a (
    .clk(clk), .rst_n(rst_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_rw(req_rw_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .busy(busy_a), .tx_out(tx_a), .rx_in(rx_a)
  );

  pvt_uart_host #(.BIT_CYCLES(4), .GAP_BITS(2), .TIMEOUT_CYCLES(255)) u_b (
    .clk(clk), .rst_n(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_rw(req_rw_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .busy(busy_b), .tx_out(tx_b), .rx_in(rx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bits[9] is the start bit, bits[0] the stop bit; each held bc cycles.
  task automatic chk_frame(input string tag, input logic [9:0] bits, input int bc, input bit sel_b);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < bc; j++) begin
        chk($sformatf("%s[%0d]", tag, i), 32'(sel_b ? tx_b : tx_a), 32'(bits[9-i]));
        tick();
      end
    end
  endtask

  task automatic rx_frame_a(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {1'b0, data, stop};
    for (int i = 0; i < 10; i++) begin
      rx_a = bits[9-i];
      tick();
    end
    rx_a = 1'b1;
  endtask

  task automatic wait_rsp(input bit sel_b, input int limit, output int n);
    n = 0;
    while (!(sel_b ? rsp_valid_b : rsp_valid_a) && n < limit) begin
      tick();
      n++;
    end
    chk("rsp_seen", 32'(sel_b ? rsp_valid_b : rsp_valid_a), 32'd1);
  endtask

  task automatic issue_a(input logic rw, input logic [4:0] addr, input logic [7:0] wdata);
    req_valid_a = 1'b1;
    req_rw_a    = rw;
    req_addr_a  = addr;
    req_wdata_a = wdata;
    tick();
    req_valid_a = 1'b0;
    req_addr_a  = 5'h1F;
    req_wdata_a = 8'hFF;
    req_rw_a    = ~rw;
  endtask

  initial begin
    int n;
    int pulses;
    rst_a = 1'b0; req_valid_a = 1'b0; req_rw_a = 1'b0; req_addr_a = '0; req_wdata_a = '0; rx_a = 1'b1;
    rst_b = 1'b0; req_valid_b = 1'b0; req_rw_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; rx_b = 1'b1;
    tick();
    tick();
    chk("rst_tx_a",    32'(tx_a),        32'd1);
    chk("rst_ready_a", 32'(req_ready_a), 32'd1);
    chk("rst_busy_a",  32'(busy_a),      32'd0);
    chk("rst_rspv_a",  32'(rsp_valid_a), 32'd0);
    chk("rst_rdata_a", 32'(rsp_rdata_a), 32'h00);
    chk("rst_err_a",   32'(rsp_err_a),   32'd0);
    chk("rst_tx_b",    32'(tx_b),        32'd1);
    chk("rst_ready_b", 32'(req_ready_b), 32'd1);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();

    // write addr 0, data 0x20
    issue_a(1'b0, 5'd0, 8'h20);
    chk("w1_ready_c1", 32'(req_ready_a), 32'd0);
    chk("w1_busy_c1",  32'(busy_a),      32'd1);
    chk_frame("w1_cmd", 10'b0_00000000_1, 1, 1'b0);
    chk_frame("w1_dat", 10'b0_00100000_1, 1, 1'b0);
    chk("w1_rspv_c21", 32'(rsp_valid_a), 32'd1);
    chk("w1_err",      32'(rsp_err_a),   32'd0);
    chk("w1_rdata",    32'(rsp_rdata_a), 32'h00);
    tick();
    chk("w1_rspv_c22", 32'(rsp_valid_a), 32'd0);
    chk("w1_ready_c22", 32'(req_ready_a), 32'd1);

    // write addr 0, data 0x00
    issue_a(1'b0, 5'd0, 8'h00);
    chk_frame("w2_cmd", 10'b0_00000000_1, 1, 1'b0);
    chk_frame("w2_dat", 10'b0_00000000_1, 1, 1'b0);
    chk("w2_rspv", 32'(rsp_valid_a), 32'd1);
    chk("w2_err",  32'(rsp_err_a),   32'd0);
    tick();

    // read addr 0, response 0x00 four cycles after command stop bit
    issue_a(1'b1, 5'd0, 8'h00);
    chk_frame("r1_cmd", 10'b0_01000000_1, 1, 1'b0);
    tick(); tick(); tick();
    rx_frame_a(8'h00, 1'b1);
    wait_rsp(1'b0, 5, n);
    chk("r1_latency", 32'(n),           32'd0);
    chk("r1_rdata",   32'(rsp_rdata_a), 32'h00);
    chk("r1_err",     32'(rsp_err_a),   32'd0);
    tick();

    // read addr 0, response 0xA5
    issue_a(1'b1, 5'd0, 8'h00);
    chk_frame("r2_cmd", 10'b0_01000000_1, 1, 1'b0);
    tick(); tick(); tick();
    rx_frame_a(8'hA5, 1'b1);
    wait_rsp(1'b0, 5, n);
    chk("r2_latency", 32'(n),           32'd0);
    chk("r2_rdata",   32'(rsp_rdata_a), 32'hA5);
    chk("r2_err",     32'(rsp_err_a),   32'd0);
    tick(); tick(); tick();
    chk("r2_hold_rspv",  32'(rsp_valid_a), 32'd0);
    chk("r2_hold_rdata", 32'(rsp_rdata_a), 32'hA5);

    // read with rx_in held high: timeout 17 cycles after RX_WAIT entry
    issue_a(1'b1, 5'd9, 8'h00);
    chk_frame("to_cmd", 10'b0_01001001_1, 1, 1'b0);
    wait_rsp(1'b0, 40, n);
    chk("to_latency", 32'(n),           32'd17);
    chk("to_err",     32'(rsp_err_a),   32'd2);
    chk("to_rdata",   32'(rsp_rdata_a), 32'h00);
    tick();

    // framing error: 0x3C with stop bit low
    issue_a(1'b1, 5'd0, 8'h00);
    chk_frame("fe_cmd", 10'b0_01000000_1, 1, 1'b0);
    tick(); tick(); tick();
    rx_frame_a(8'h3C, 1'b0);
    wait_rsp(1'b0, 5, n);
    chk("fe_latency", 32'(n),           32'd0);
    chk("fe_err",     32'(rsp_err_a),   32'd1);
    chk("fe_rdata",   32'(rsp_rdata_a), 32'h00);
    tick();
    chk("fe_ready_next", 32'(req_ready_a), 32'd1);
    chk("fe_busy_next",  32'(busy_a),      32'd0);
    chk("fe_rspv_next",  32'(rsp_valid_a), 32'd0);

    // reset in cycle 5 of a write
    issue_a(1'b0, 5'd3, 8'h55);
    tick(); tick(); tick(); tick();
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    chk("mr_tx",    32'(tx_a),        32'd1);
    chk("mr_busy",  32'(busy_a),      32'd0);
    chk("mr_ready", 32'(req_ready_a), 32'd1);
    chk("mr_rspv",  32'(rsp_valid_a), 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      pulses += int'(rsp_valid_a);
    end
    chk("mr_no_rsp", 32'(pulses), 32'd0);
    chk("mr_tx_idle", 32'(tx_a), 32'd1);

    // instance b: 4 cycles/bit, 2 gap bits; req_valid kept high with new fields
    req_valid_b = 1'b1; req_rw_b = 1'b0; req_addr_b = 5'd5; req_wdata_b = 8'hFF;
    tick();
    req_rw_b = 1'b1; req_addr_b = 5'h1F; req_wdata_b = 8'h00;
    chk("b_ready_c1", 32'(req_ready_b), 32'd0);
    chk_frame("b_cmd", 10'b0_00000101_1, 4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b_gap_tx[%0d]", i),    32'(tx_b),        32'd1);
      chk($sformatf("b_gap_busy[%0d]", i),  32'(busy_b),      32'd1);
      chk($sformatf("b_gap_ready[%0d]", i), 32'(req_ready_b), 32'd0);
      tick();
    end
    chk_frame("b_dat", 10'b0_11111111_1, 4, 1'b1);
    chk("b_rspv_c89", 32'(rsp_valid_b), 32'd1);
    chk("b_err",      32'(rsp_err_b),   32'd0);
    chk("b_rdata",    32'(rsp_rdata_b), 32'h00);
    tick();
    chk("b_ready_c90", 32'(req_ready_b), 32'd1);
    chk("b_rspv_c90",  32'(rsp_valid_b), 32'd0);
    tick();
    req_valid_b = 1'b0;
    chk("b_reaccept_busy",  32'(busy_b),      32'd1);
    chk("b_reaccept_ready", 32'(req_ready_b), 32'd0);
    chk_frame("b_rd_cmd", 10'b0_01011111_1, 4, 1'b1);
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    chk("b_rst_busy", 32'(busy_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pvt_uart_host.md
Name: pvt_uart_host

Overview:
- Host-side initiator for the PVT sensor wrapper's single-wire serial command link.
- Accepts register write/read requests on a valid/ready interface and serializes command frames onto tx_out, which drives the wrapper's rx.
- For reads, deserializes the wrapper's response frame from rx_in and returns the byte with error status.
- Used by on-chip controllers and as the bench driver for the sensor wrapper.

Parameters:
- BIT_CYCLES, 1, clock cycles per serial bit (>=1)
- GAP_BITS, 0, idle-high bit periods inserted between the two frames of a write
- TIMEOUT_CYCLES, 255, max cycles in RX_WAIT before a read fails (>=1)

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept request (high only in IDLE)
- req_rw  input  1  0=write, 1=read
- req_addr  input  5  sensor/register address
- req_wdata  input  8  write data byte (ignored for reads)
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  8  read data (0x00 for writes and errors)
- rsp_err  output  2  00 ok, 01 framing error (stop bit low), 10 timeout
- busy  output  1  high in any state other than IDLE
- tx_out  output  1  serial out to wrapper rx, idles high
- rx_in  input  1  serial in from wrapper tx, idles high, same clock domain (no synchronizer)

Behaviour:
- Reset (clk edge with rst_n=0), from any state including mid-frame:
  - state=IDLE, tx_out=1, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all counters cleared.
  - An interrupted frame is abandoned; no response is issued.
- Frame format:
  - start bit 0, then 8 data bits MSB first, then stop bit 1.
  - Each bit is held for BIT_CYCLES cycles, so one frame lasts 10*BIT_CYCLES cycles.
- Command byte = {type[2:0], addr[4:0]}; type 3'd0 = write, 3'd2 = read. Other types are never generated.
- Write transaction:
  - command frame {3'd0, req_addr}
  - then GAP_BITS*BIT_CYCLES idle-high cycles
  - then data frame = req_wdata (raw 8 bits).
- Read transaction: command frame {3'd2, req_addr}, then receive one response frame.
- Handshake:
  - A request is accepted on a clock edge where req_valid & req_ready. Call that cycle 0.
  - req_addr, req_wdata and req_rw are latched at acceptance; later input changes are ignored.
  - req_ready drops in cycle 1. The start bit appears on tx_out in cycle 1 (tx_out is registered).
- States: IDLE, TX_START, TX_DATA, TX_STOP, TX_GAP, RX_WAIT, RX_DATA, RX_STOP, DONE.
  - IDLE -> TX_START on accept.
  - TX_START -> TX_DATA -> TX_STOP, with bit counter 7..0.
  - After TX_STOP of the command frame:
    - write with GAP_BITS>0 -> TX_GAP -> TX_START (data frame)
    - write with GAP_BITS=0 -> TX_START (data frame)
    - read -> RX_WAIT
  - After TX_STOP of the data frame -> DONE.
  - RX_WAIT:
    - rx_in sampled 0 -> RX_DATA. The start is detected at edge t.
    - Data bit k (MSB first, k=1..8) is sampled at t + k*BIT_CYCLES.
    - RX_STOP samples the stop bit at t + 9*BIT_CYCLES.
  - RX_STOP: stop=1 -> DONE with err=00 and rdata=shifted byte; stop=0 -> DONE with err=01 and rdata=0x00.
  - RX_WAIT timeout: the counter starts at 0 on RX_WAIT entry. If it reaches TIMEOUT_CYCLES with no low sample -> DONE with err=10 and rdata=0x00.
  - DONE: rsp_valid=1 for exactly one cycle with rsp_rdata/rsp_err valid that cycle, then -> IDLE (req_ready=1 the following cycle).
- Latency with BIT_CYCLES=1, GAP_BITS=0:
  - Write: frames occupy cycles 1-20; rsp_valid in cycle 21.
  - Read: command occupies cycles 1-10; RX_WAIT from cycle 11.
- rx_in is ignored in every state except RX_WAIT/RX_DATA/RX_STOP. Low glitches during TX are not detected.
- A start bit arriving in the same cycle the timeout counter hits its limit counts as a start; the timeout is not reported.
- rsp_rdata/rsp_err hold their last values after rsp_valid falls, until the next DONE or reset.

Test Plan:
- Reset mid-frame: accept a write, assert rst_n=0 in cycle 5 -> next cycle tx_out=1, busy=0, req_ready=1, no rsp_valid.
- Write addr=0, wdata=0x20 (BIT_CYCLES=1):
  - tx_out over cycles 1-10 = 0,0,0,0,0,0,0,0,0,1
  - tx_out over cycles 11-20 = 0,0,0,1,0,0,0,0,0,1
  - rsp_valid in cycle 21 with err=00
  - a second write addr=0, wdata=0x00 gives an all-zero data frame.
- Read addr=0: command bits = 0,0,1,0,0,0,0,0,0,1. Responder returns 0x00 four cycles after the stop bit -> rsp_rdata=0x00, err=00. Repeat with response 0xA5 -> rsp_rdata=0xA5.
- Framing error: responder sends 0x3C with stop bit 0 -> rsp_valid, err=01, rdata=0x00, block back in IDLE next cycle.
- Timeout: TIMEOUT_CYCLES=16, read with rx_in held high -> rsp_valid exactly 17 cycles after RX_WAIT entry, err=10.
- BIT_CYCLES=4, GAP_BITS=2 write addr=5, wdata=0xFF:
  - command frame {000,00101} has each bit held 4 cycles
  - 8 idle-high cycles between frames
  - rsp_valid at cycle 89
  - req_valid held during busy is not accepted until req_ready returns.
